// File: rtl/mesh_chain.sv
// Linear mesh of STAGES switches with an elastic valid/ready token pipeline
// and a drain-then-load serial config chain. Optional macro: MESH_CHAIN_SAT_EN.
module mesh_chain #(
  parameter int STAGES = 4,
  parameter int WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_req,
  input  logic                    cfg_valid,
  input  logic [WIDTH+2:0]        cfg_data,
  output logic                    cfg_ready,
  output logic                    cfg_done,
  output logic                    busy,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_ready,
  input  logic [STAGES*WIDTH-1:0] lane_data,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready
);

  localparam int CW   = WIDTH + 3;
  localparam int CNTW = $clog2(STAGES + 1);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    LOAD
  } state_t;

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [CW-1:0]     cfg_q   [STAGES];
  logic [WIDTH-1:0]  data_q  [STAGES];
  logic [STAGES-1:0] valid_q;

  logic [STAGES-1:0] stage_ready;
  logic [STAGES-1:0] feed_valid;
  logic [WIDTH-1:0]  feed_data [STAGES];
  logic [WIDTH-1:0]  result    [STAGES];
  logic [STAGES-1:0] low_mask;
  logic              in_fire;
  logic              cfg_fire;

  function automatic logic [WIDTH-1:0] alu(
    input logic [CW-1:0]    c,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] lane
  );
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] r;
    b = c[WIDTH] ? lane : c[WIDTH-1:0];
    s = '0;
    r = a;
    unique case (c[CW-1:CW-2])
      2'b00: r = a;
      2'b01: begin
        s = {1'b0, a} + {1'b0, b};
`ifdef MESH_CHAIN_SAT_EN
        r = s[WIDTH] ? '1 : s[WIDTH-1:0];
`else
        r = s[WIDTH-1:0];
`endif
      end
      2'b10: begin
        s = {1'b0, a} - {1'b0, b};
`ifdef MESH_CHAIN_SAT_EN
        r = s[WIDTH] ? '0 : s[WIDTH-1:0];
`else
        r = s[WIDTH-1:0];
`endif
      end
      2'b11: r = a ^ b;
    endcase
    return r;
  endfunction

  // Stage i can load when any stage from i to the tail has room,
  // expressed without a combinational chain through stage_ready.
  always_comb begin
    stage_ready = '0;
    low_mask    = '0;
    for (int i = 0; i < STAGES; i++) begin
      low_mask       = (STAGES)'(((STAGES+1)'(1) << i) - 1'b1);
      stage_ready[i] = out_ready || !(&(valid_q | low_mask));
    end
  end

  assign in_ready = (state == RUN) && !load_req && stage_ready[0];
  assign in_fire  = in_valid && in_ready;
  assign cfg_ready = (state == LOAD);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign busy      = (state != RUN);
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

  always_comb begin
    feed_valid = '0;
    for (int i = 0; i < STAGES; i++) begin
      feed_data[i] = '0;
      result[i]    = '0;
    end
    feed_valid[0] = in_fire;
    feed_data[0]  = in_data;
    for (int i = 1; i < STAGES; i++) begin
      feed_valid[i] = valid_q[i-1];
      feed_data[i]  = data_q[i-1];
    end
    for (int i = 0; i < STAGES; i++)
      result[i] = alu(cfg_q[i], feed_data[i], lane_data[i*WIDTH +: WIDTH]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (stage_ready[i]) begin
          valid_q[i] <= feed_valid[i];
          if (feed_valid[i]) data_q[i] <= result[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      cnt      <= '0;
      cfg_done <= 1'b0;
      for (int i = 0; i < STAGES; i++) cfg_q[i] <= '0;
    end else begin
      cfg_done <= 1'b0;
      unique case (state)
        RUN: if (load_req) state <= DRAIN;
        DRAIN: if (valid_q == '0) state <= LOAD;
        LOAD: begin
          if (cfg_fire) begin
            for (int k = STAGES - 1; k > 0; k--) cfg_q[k] <= cfg_q[k-1];
            cfg_q[0] <= cfg_data;
            if (cnt == CNTW'(STAGES - 1)) begin
              cnt      <= '0;
              cfg_done <= 1'b1;
              state    <= RUN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_chain.sv
// Scoreboard bench for mesh_chain: random tokens and configs against an
// arithmetic reference model (honours MESH_CHAIN_SAT_EN).
module tb_mesh_chain;
  localparam int S = 4;
  localparam int W = 32;

  logic           clk = 0;
  logic           reset = 1;
  logic           load_req = 0;
  logic           cfg_valid = 0;
  logic [W+2:0]   cfg_data = '0;
  logic           cfg_ready, cfg_done, busy;
  logic           in_valid = 0;
  logic [W-1:0]   in_data = '0;
  logic           in_ready;
  logic [S*W-1:0] lane_data;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready = 1;

  mesh_chain #(.STAGES(S), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load_req(load_req),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .busy(busy),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .lane_data(lane_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] expq[$];
  logic [W+2:0] m_cfg[S];
  logic [W-1:0] lane[S];
  logic [W+2:0] words[S];

  always_comb begin
    lane_data = '0;
    for (int i = 0; i < S; i++) lane_data[i*W +: W] = lane[i];
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W+2:0] mk(input int op, input bit src,
                                      input logic [W-1:0] imm);
    return {op[1:0], src, imm};
  endfunction

  // Reference: walk the stages with plain 64-bit arithmetic.
  function automatic logic [W-1:0] ref_out(input logic [W-1:0] v);
    longint t, b, lim;
    int op;
    lim = 64'hFFFF_FFFF;
    t = longint'(v);
    for (int i = 0; i < S; i++) begin
      op = int'(m_cfg[i][W+2:W+1]);
      b = m_cfg[i][W] ? longint'(lane[i]) : longint'(m_cfg[i][W-1:0]);
      if (op == 1) begin
        t = t + b;
`ifdef MESH_CHAIN_SAT_EN
        if (t > lim) t = lim;
`endif
      end else if (op == 2) begin
        t = t - b;
`ifdef MESH_CHAIN_SAT_EN
        if (t < 0) t = 0;
`endif
      end else if (op == 3) begin
        t = t ^ b;
      end
      t = t & lim;
    end
    return t[W-1:0];
  endfunction

  logic         hold = 0;
  logic [W-1:0] hold_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      hold = 0;
    end else begin
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected none", out_data);
        end else begin
          check("out_data", out_data, expq.pop_front());
        end
      end
      hold = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v);
    int n = 0;
    in_valid = 1;
    in_data = v;
    #1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (in_ready) begin
      expq.push_back(ref_out(v));
    end else begin
      check("send_timeout", 0, 1);
    end
    tick();
    in_valid = 0;
  endtask

  task automatic load(input int nw);
    int n = 0;
    load_req = 1;
    #1;
    check("ldreq_in_ready", in_ready, 0);
    tick();
    load_req = 0;
    in_valid = 0;
    check("busy", busy, 1);
    while (!cfg_ready && n < 50) begin
      tick();
      n++;
    end
    check("cfg_ready_rise", cfg_ready, 1);
    check("drained", expq.size(), 0);
    for (int j = 0; j < nw; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg_valid = 0;
        tick();
      end
      cfg_valid = 1;
      cfg_data = words[j];
      tick();
    end
    cfg_valid = 0;
    if (nw == S) begin
      check("cfg_done", cfg_done, 1);
      check("done_busy", busy, 0);
      check("done_cfg_ready", cfg_ready, 0);
      for (int j = 0; j < S; j++) m_cfg[S-1-j] = words[j];
      tick();
      check("cfg_done_pulse", cfg_done, 0);
    end
  endtask

  task automatic wait_empty;
    int n = 0;
    while ((expq.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    check("wait_empty", expq.size(), 0);
  endtask

  initial begin
    int tok;
    for (int i = 0; i < S; i++) begin
      lane[i] = '0;
      m_cfg[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_busy", busy, 0);
    reset = 0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Default pass-through and latency
    send(32'h5);
    check("lat0", out_valid, 0);
    tick();
    check("lat1", out_valid, 0);
    tick();
    check("lat2", out_valid, 0);
    tick();
    check("lat3", out_valid, 1);
    repeat (3) tick();

    // Program: stage3 PASS, stage2 XOR FF, stage1 SUB lane, stage0 ADD 1
    lane[1] = 32'd3;
    words[0] = mk(0, 0, 0);
    words[1] = mk(3, 0, 32'hFF);
    words[2] = mk(2, 1, 0);
    words[3] = mk(1, 0, 32'd1);
    load(S);
    check("ref_f7", ref_out(32'd10), 32'hF7);
    send(32'd10);
    repeat (6) tick();

    // Backpressure: 6 offered, only S fit
    out_ready = 0;
    #1;
    tok = 1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (tok <= 6);
      in_data = tok;
      if (in_valid && in_ready) begin
        expq.push_back(ref_out(tok));
        tok++;
      end
      tick();
    end
    in_valid = 0;
    check("bp_accepted", tok - 1, 4);
    check("bp_in_ready", in_ready, 0);
    out_ready = 1;
    while (tok <= 6) begin
      send(tok);
      tok++;
    end
    wait_empty();

    // Drain with two tokens in flight; stage0 becomes ADD 1
    send(32'h11);
    send(32'h22);
    in_valid = 1;
    in_data = 32'hDEAD;
    for (int j = 0; j < S - 1; j++) words[j] = mk(0, 0, 0);
    words[S-1] = mk(1, 0, 32'd1);
    load(S);
    send(32'hFFFF_FFFF);
    wait_empty();
    words[S-1] = mk(2, 0, 32'd1);
    load(S);
    send(32'h0);
    wait_empty();

    // Random configs and traffic
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < S; i++) begin
        lane[i] = $urandom;
        words[i] = mk($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      $urandom);
      end
      load(S);
      for (int c = 0; c < 150; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        in_valid = $urandom_range(0, 1);
        in_data = (c % 16 == 0) ? 32'hFFFF_FFFF : $urandom;
        #1;
        if (in_valid && in_ready) expq.push_back(ref_out(in_data));
        tick();
      end
      in_valid = 0;
      out_ready = 1;
      wait_empty();
    end

    // Reset in the middle of a load
    for (int i = 0; i < S; i++) words[i] = mk(1, 0, 32'h77);
    load(2);
    reset = 1;
    #1;
    check("mid_rst_cfg_ready", cfg_ready, 0);
    check("mid_rst_busy", busy, 0);
    for (int i = 0; i < S; i++) m_cfg[i] = '0;
    tick();
    reset = 0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    send(32'h1234);
    wait_empty();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
